// File: rtl/cnn_infer_ctrl.sv
// cnn_infer_ctrl
//   Inference sequencer for the three-stage CNN classifier. A debounced
//   button press latches the switch-selected image index and fires a
//   one-cycle start at the image source. The controller then waits for the
//   dense layer's result, scans the class scores one per cycle for the
//   largest signed value (ties go to the lowest index) and holds the winner
//   on the LEDs until the next run.
//
//   Optional feature macro: CNN_INFER_CTRL_WDT_EN
//     defined   : a watchdog aborts a run whose dense result never arrives
//                 within WDT_CYCLES RUN cycles; timeout_o and led_o[7] flag it.
//     undefined : RUN waits indefinitely and timeout_o is tied low.
//
// Ports
//   clk            in   system clock
//   resetn         in   asynchronous active-low reset
//   sw[3:0]        in   image select, latched when a run is accepted
//   button         in   raw push button (asynchronous, active-high)
//   dense_valid    in   one-cycle pulse, dense_out holds a new result
//   dense_out      in   NUM_CLASS signed scores, class i at [i*DATA_BITS +: DATA_BITS]
//   img_sel_o[3:0] out  image index latched at start
//   img_start_o    out  one-cycle start pulse to the image source
//   busy_o         out  high while a run is in progress
//   class_o[2:0]   out  winning class index
//   result_valid_o out  one-cycle pulse when class_o updates
//   timeout_o      out  sticky watchdog flag for the last run
//   led_o[7:0]     out  [6:0] one-hot of the result, [7] = timeout_o
module cnn_infer_ctrl #(
    parameter int NUM_CLASS  = 7,
    parameter int DATA_BITS  = 8,
    parameter int DB_CYCLES  = 100000,
    parameter int WDT_CYCLES = 2000000
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [3:0]                     sw,
    input  logic                           button,
    input  logic                           dense_valid,
    input  logic [NUM_CLASS*DATA_BITS-1:0] dense_out,
    output logic [3:0]                     img_sel_o,
    output logic                           img_start_o,
    output logic                           busy_o,
    output logic [2:0]                     class_o,
    output logic                           result_valid_o,
    output logic                           timeout_o,
    output logic [7:0]                     led_o
);

    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_ARGMAX,
        S_SHOW
    } state_t;

    state_t state_q, state_d;

    function automatic logic signed [DATA_BITS-1:0] score_at(
        input logic [NUM_CLASS*DATA_BITS-1:0] vec,
        input logic [IDX_W-1:0]               i
    );
        score_at = $signed(vec[i*DATA_BITS +: DATA_BITS]);
    endfunction

    function automatic logic [NUM_CLASS-1:0] one_hot(input logic [IDX_W-1:0] i);
        one_hot = NUM_CLASS'(1) << i;
    endfunction

    // ---- stage p0/p1: button synchronizer, debounce and edge detect ----
    logic            btn_sync_p0, btn_sync_p1;
    logic            btn_db;
    logic [DB_W-1:0] db_cnt;
    logic            go;
    logic            db_flip;

    // The debounced level follows the synchronized one only after they have
    // disagreed for DB_CYCLES consecutive cycles; agreement resets the count.
    assign db_flip = (btn_sync_p1 != btn_db) && (db_cnt == DB_W'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            btn_db      <= 1'b0;
            db_cnt      <= '0;
            go          <= 1'b0;
        end else begin
            btn_sync_p0 <= button;
            btn_sync_p1 <= btn_sync_p0;
            if (btn_sync_p1 == btn_db) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                db_cnt <= '0;
                btn_db <= btn_sync_p1;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            // Registered rising edge of the debounced level.
            go <= db_flip & btn_sync_p1;
        end
    end

    // ---- control decode ----
    logic                        accept_go;
    logic                        capture;
    logic                        last_cmp;
    logic                        wdt_hit;
    logic                        wdt_expire;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            best_idx;
    logic [IDX_W-1:0]            winner;
    logic [NUM_CLASS*DATA_BITS-1:0] score_q;
    logic signed [DATA_BITS-1:0] best_score;
    logic signed [DATA_BITS-1:0] cur_score;
    logic                        better;
    logic [NUM_CLASS-1:0]        led_cls;
    logic                        timeout_q;

    assign accept_go  = ((state_q == S_IDLE) || (state_q == S_SHOW)) && go;
    assign capture    = (state_q == S_RUN) && dense_valid;
    assign last_cmp   = (state_q == S_ARGMAX) && (idx == LAST_IDX);
    // A result arriving on the terminal watchdog count still wins.
    assign wdt_expire = (state_q == S_RUN) && !dense_valid && wdt_hit;

    assign cur_score  = score_at(score_q, idx);
    // Strictly greater: on a tie the earlier (lower) index is kept.
    assign better     = cur_score > best_score;
    assign winner     = better ? idx : best_idx;

    // ---- watchdog ----
`ifdef CNN_INFER_CTRL_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;

    // Cleared during ARM so it reads 0 in the first RUN cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt_cnt <= '0;
        end else if (state_q == S_ARM) begin
            wdt_cnt <= '0;
        end else if (state_q == S_RUN) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign wdt_hit = (state_q == S_RUN) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_q <= 1'b0;
        end else if (accept_go) begin
            timeout_q <= 1'b0;
        end else if (wdt_expire) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign wdt_hit   = 1'b0;
    assign timeout_q = 1'b0;
`endif

    // ---- FSM ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_SHOW: begin
                if (go) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (dense_valid) begin
                    state_d = S_ARGMAX;
                end else if (wdt_hit) begin
                    state_d = S_SHOW;
                end
            end
            S_ARGMAX: begin
                if (idx == LAST_IDX) state_d = S_SHOW;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---- stage p2: score capture and running maximum ----
    always_ff @(posedge clk) begin
        if (capture) begin
            score_q    <= dense_out;
            best_score <= score_at(dense_out, '0);
        end else if ((state_q == S_ARGMAX) && better) begin
            best_score <= cur_score;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx            <= '0;
            best_idx       <= '0;
            class_o        <= '0;
            led_cls        <= '0;
            result_valid_o <= 1'b0;
            img_sel_o      <= '0;
        end else begin
            result_valid_o <= 1'b0;
            if (accept_go) begin
                img_sel_o <= sw;
            end
            if (capture) begin
                idx      <= IDX_W'(1);
                best_idx <= '0;
            end else if (state_q == S_ARGMAX) begin
                idx <= idx + 1'b1;
                if (better) best_idx <= idx;
            end
            if (last_cmp) begin
                class_o        <= winner;
                led_cls        <= one_hot(winner);
                result_valid_o <= 1'b1;
            end
            // A timed-out run shows only the timeout LED.
            if (wdt_expire) begin
                led_cls <= '0;
            end
        end
    end

    // ---- outputs ----
    assign img_start_o = (state_q == S_ARM);
    assign busy_o      = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_ARGMAX);
    assign timeout_o   = timeout_q;
    assign led_o       = {timeout_q, led_cls};

endmodule

// File: doc/cnn_infer_ctrl.md
# cnn_infer_ctrl

Inference sequencer for the three-stage CNN classifier. It sits between the board I/O (switches, push button, LEDs) and the CNN datapath. On a debounced button press it latches the switch-selected image and issues a one-cycle start to the image source. It then waits for the dense layer's valid, computes the argmax over the 7 class scores sequentially, and holds the winning class on the LEDs until the next run. An optional watchdog aborts a run whose dense result never arrives.

## Interface
Parameters:
- `NUM_CLASS`, 7: number of dense-layer outputs; fixed at 7 for the LED mapping.
- `DATA_BITS`, 8: width of one class score, signed two's complement.
- `DB_CYCLES`, 100000: consecutive stable cycles required to accept a new button level.
- `WDT_CYCLES`, 2000000: RUN-state cycles allowed before a timeout (used only with the watchdog macro).

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `sw`  in  4  image select.
- `button`  in  1  raw push button, asynchronous to `clk`, active-high.
- `dense_valid`  in  1  one-cycle pulse: `dense_out` holds a new result.
- `dense_out`  in  NUM_CLASS*DATA_BITS  class scores; class i is `[i*8 +: 8]`.
- `img_sel_o`  out  4  image index latched at start.
- `img_start_o`  out  1  one-cycle start pulse to the image source.
- `busy_o`  out  1  high in ARM, RUN and ARGMAX.
- `class_o`  out  3  winning class index.
- `result_valid_o`  out  1  one-cycle pulse when `class_o` updates.
- `timeout_o`  out  1  sticky watchdog flag for the last run.
- `led_o`  out  8  `[6:0]` one-hot of `class_o`, `[7]` equals `timeout_o`.

## Operation
- **Button front end**
  - 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized level has differed from it for `DB_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level produces a one-cycle `go`.
- **FSM states:** IDLE, ARM, RUN, ARGMAX, SHOW.
  - IDLE/SHOW + `go` → ARM. `sw` is latched into `img_sel_o`, and `timeout_o` clears.
  - ARM → RUN, unconditionally after 1 cycle. `img_start_o` is high in ARM only.
  - RUN + `dense_valid` → ARGMAX. All scores are captured into an internal register. The best score is initialised to class 0, and the index counter to 1.
  - ARGMAX: one class compared per cycle, for indices 1..6. The signed compare replaces the best only if strictly greater, so ties resolve to the lowest index. After index 6 → SHOW.
  - SHOW: on entry, `class_o`, `led_o[6:0]` and `result_valid_o` (1 cycle) update. The state holds until `go`.
- **Ignored inputs**
  - `go` in ARM, RUN or ARGMAX is ignored and not queued.
  - `dense_valid` outside RUN is ignored.
  - `dense_out` is not sampled except in the `dense_valid` cycle of RUN.
- **Held outputs:** `class_o` and `led_o` keep the previous result through a new run until it completes.

## Timing
- Reset (asynchronous assert, synchronous deassert at the system level):
  - State is IDLE, and the debounced level and all counters are 0.
  - All outputs are 0, including `led_o` = 8'h00.
- `go` registered high in cycle T (IDLE or SHOW): the state is ARM and `img_start_o` = 1 in T+1, and the state is RUN in T+2.
- `dense_valid` high in RUN at cycle V:
  - ARGMAX occupies V+1..V+6.
  - In V+7 the state is SHOW, with `result_valid_o` = 1 and `class_o`/`led_o` valid.
  - Fixed latency from `dense_valid` to result: 7 cycles.
- Button press to `go`: 2 synchronizer cycles, plus `DB_CYCLES`, plus 1 edge-detect cycle.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No `img_start_o` or `result_valid_o` is generated by the deassertion.

## Configuration
- Macro: `CNN_INFER_CTRL_WDT_EN`.
- **Defined:**
  - A counter runs in RUN. It is cleared on entering RUN.
  - If it reaches `WDT_CYCLES - 1` without `dense_valid`, the next state is SHOW with `timeout_o` = 1 and `led_o` = 8'h80.
  - `class_o` is unchanged and no `result_valid_o` pulse occurs.
  - If `dense_valid` arrives in the same cycle as the terminal count, `dense_valid` wins.
- **Undefined:** RUN waits indefinitely, `timeout_o` is tied to 0, and no counter is instantiated.

## Test plan
All scenarios use `DB_CYCLES`=4, `WDT_CYCLES`=100 and the macro defined, unless stated otherwise.
- **Debounce:** toggle `button` every 2 cycles for 20 cycles, then hold it high.
  - No `img_start_o` while toggling.
  - Exactly one `img_start_o` after it is held, with `img_sel_o` equal to `sw` (4'hA).
- **Argmax:** scores {−5, 17, 3, 17, −128, 0, 16} (class 0..6), `dense_valid` at V.
  - `result_valid_o` at V+7, `class_o` = 1 (tie goes to the lower index), `led_o` = 8'h02.
- **All negative:** scores {−1, −2, −3, −4, −5, −6, −7}.
  - `class_o` = 0, `led_o` = 8'h01.
- **Ignored events:**
  - Press the button during RUN: no second `img_start_o`.
  - `dense_valid` in IDLE: no `result_valid_o`.
- **Watchdog:** no `dense_valid` after start.
  - SHOW entered 100 cycles after RUN entry, `timeout_o` = 1, `led_o` = 8'h80.
  - A new press clears `timeout_o`.
  - With the macro undefined, the FSM stays in RUN and `timeout_o` stays 0.
- **Mid-run reset:** assert `resetn` = 0 in ARGMAX.
  - All outputs are 0 asynchronously and the state is IDLE.
  - After release, there is no pulse until the next press.
